// File: rtl/fpgaminer_pkg.sv
// rtl/fpgaminer_pkg.sv - shared widths and constants for the mining datapath
package fpgaminer_pkg;

   localparam int NONCE_W = 32;
   localparam logic [NONCE_W-1:0] EMPTY_NONCE = 32'hFFFF_FFFF;
   localparam int PIPE_HOLDOFF = 254;

   // Counter width able to hold 0..max; never narrower than one bit.
   function automatic int cnt_width(input int max_value);
      return (max_value > 0) ? $clog2(max_value + 1) : 1;
   endfunction

endpackage

// File: rtl/nonce_fifo_mem.sv
// rtl/nonce_fifo_mem.sv - nonce storage array, one write port, asynchronous read port
module nonce_fifo_mem
   import fpgaminer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               hash_clk,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [NONCE_W-1:0] wr_data,
   input  logic [AW-1:0]      rd_addr,
   output logic [NONCE_W-1:0] rd_data
);

   logic [NONCE_W-1:0] mem [DEPTH];

   always_ff @(posedge hash_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/golden_nonce_queue.sv
// rtl/golden_nonce_queue.sv - golden nonce FIFO with post-new-work holdoff window
module golden_nonce_queue
   import fpgaminer_pkg::*;
#(
   parameter int                 DEPTH       = 8,
   parameter int                 HOLDOFF     = PIPE_HOLDOFF,
   parameter logic [NONCE_W-1:0] EMPTY_VALUE = EMPTY_NONCE
) (
   input  logic                       hash_clk,
   input  logic                       reset,
   input  logic                       rx_new_nonce,
   input  logic [NONCE_W-1:0]         rx_golden_nonce,
   input  logic                       rx_flush,
   input  logic                       rx_pop,
   output logic                       tx_valid,
   output logic [NONCE_W-1:0]         tx_nonce,
   output logic [$clog2(DEPTH):0]     tx_count,
   output logic [15:0]                tx_overflow_count,
   output logic                       tx_holdoff
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = cnt_width(HOLDOFF);

   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count;
   logic [HW-1:0]      holdoff_cnt;
   logic [15:0]        overflow_cnt;
   logic [NONCE_W-1:0] head_data;
   logic               full, pop_ok, push_ok, push_drop;

   assign full      = (count == CW'(DEPTH));
   assign pop_ok    = rx_pop && (count != '0);
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign push_ok   = rx_new_nonce && (holdoff_cnt == '0) && (!full || pop_ok);
   assign push_drop = rx_new_nonce && (holdoff_cnt == '0) && full && !pop_ok;

   nonce_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .hash_clk (hash_clk),
      .wr_en    (push_ok && !rx_flush && !reset),
      .wr_addr  (wr_ptr),
      .wr_data  (rx_golden_nonce),
      .rd_addr  (rd_ptr),
      .rd_data  (head_data)
   );

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         holdoff_cnt  <= '0;
         overflow_cnt <= '0;
      end else if (rx_flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         holdoff_cnt <= HW'(HOLDOFF);
      end else begin
         if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - HW'(1);
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
         end else if (pop_ok && !push_ok) begin
            count <= count - CW'(1);
         end
         if (push_drop && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 16'd1;
         end
      end
   end

   assign tx_valid          = (count != '0);
   assign tx_nonce          = tx_valid ? head_data : EMPTY_VALUE;
   assign tx_count          = count;
   assign tx_overflow_count = overflow_cnt;
   assign tx_holdoff        = (holdoff_cnt != '0);

endmodule

// File: tb/tb_golden_nonce_queue.sv
// tb/tb_golden_nonce_queue.sv - self-checking bench for golden_nonce_queue
module tb_golden_nonce_queue;

   localparam int DEPTH   = 8;
   localparam int HOLDOFF = 254;

   logic        hash_clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_new_nonce = 1'b0;
   logic [31:0] rx_golden_nonce = '0;
   logic        rx_flush = 1'b0;
   logic        rx_pop = 1'b0;
   logic        tx_valid;
   logic [31:0] tx_nonce;
   logic [3:0]  tx_count;
   logic [15:0] tx_overflow_count;
   logic        tx_holdoff;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mq[$];
   int          m_ovf  = 0;
   int          m_hold = 0;

   typedef struct {
      bit          push;
      logic [31:0] data;
      bit          pop;
      bit          exp_valid;
      logic [31:0] exp_nonce;
      int          exp_count;
   } vec_t;

   vec_t vecs[6];

   golden_nonce_queue #(
      .DEPTH       (DEPTH),
      .HOLDOFF     (HOLDOFF),
      .EMPTY_VALUE (32'hFFFF_FFFF)
   ) dut (
      .hash_clk          (hash_clk),
      .reset             (reset),
      .rx_new_nonce      (rx_new_nonce),
      .rx_golden_nonce   (rx_golden_nonce),
      .rx_flush          (rx_flush),
      .rx_pop            (rx_pop),
      .tx_valid          (tx_valid),
      .tx_nonce          (tx_nonce),
      .tx_count          (tx_count),
      .tx_overflow_count (tx_overflow_count),
      .tx_holdoff        (tx_holdoff)
   );

   always #5 hash_clk = ~hash_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, 32'(tx_valid), 32'(mq.size() != 0));
      chk({tag, ".nonce"}, tx_nonce, (mq.size() != 0) ? mq[0] : 32'hFFFF_FFFF);
      chk({tag, ".count"}, 32'(tx_count), 32'(mq.size()));
      chk({tag, ".ovf"}, 32'(tx_overflow_count), 32'(m_ovf));
      chk({tag, ".holdoff"}, 32'(tx_holdoff), 32'(m_hold != 0));
   endtask

   // Drive one cycle, advance the reference model by the same edge, sample 1 time unit later.
   task automatic step(input bit rst, input bit push, input logic [31:0] d, input bit pop, input bit flush);
      bit pop_ok, push_ok;
      reset = rst; rx_new_nonce = push; rx_golden_nonce = d; rx_pop = pop; rx_flush = flush;
      @(posedge hash_clk);
      if (rst) begin
         mq.delete(); m_hold = 0; m_ovf = 0;
      end else if (flush) begin
         mq.delete(); m_hold = HOLDOFF;
      end else begin
         pop_ok  = pop && (mq.size() > 0);
         push_ok = push && (m_hold == 0) && ((mq.size() < DEPTH) || pop_ok);
         if (push && m_hold == 0 && !push_ok && m_ovf < 65535) m_ovf++;
         if (pop_ok) void'(mq.pop_front());
         if (push_ok) mq.push_back(d);
         if (m_hold > 0) m_hold--;
      end
      #1;
      reset = 1'b0; rx_new_nonce = 1'b0; rx_pop = 1'b0; rx_flush = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, ".valid"}, 32'(tx_valid), 32'd0);
      chk({tag, ".nonce"}, tx_nonce, 32'hFFFF_FFFF);
      chk({tag, ".count"}, 32'(tx_count), 32'd0);
      chk({tag, ".ovf"}, 32'(tx_overflow_count), 32'd0);
      chk({tag, ".holdoff"}, 32'(tx_holdoff), 32'd0);
   endtask

   initial begin
      int hold_cycles;
      logic [31:0] exp_pops[$];

      vecs[0] = '{1, 32'h10, 0, 1, 32'h10, 1};
      vecs[1] = '{1, 32'h20, 0, 1, 32'h10, 2};
      vecs[2] = '{1, 32'h30, 0, 1, 32'h10, 3};
      vecs[3] = '{0, 32'h0,  1, 1, 32'h20, 2};
      vecs[4] = '{0, 32'h0,  1, 1, 32'h30, 1};
      vecs[5] = '{0, 32'h0,  1, 0, 32'hFFFF_FFFF, 0};

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      chk_reset_values("reset_idle");

      for (int i = 0; i < 6; i++) begin
         step(0, vecs[i].push, vecs[i].data, vecs[i].pop, 0);
         chk($sformatf("vec%0d.valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d.nonce", i), tx_nonce, vecs[i].exp_nonce);
         chk($sformatf("vec%0d.count", i), 32'(tx_count), 32'(vecs[i].exp_count));
      end

      // Empty queue: pop ignored, push stored.
      step(0, 1, 32'hABCD, 1, 0);
      chk("empty_pushpop.count", 32'(tx_count), 32'd1);
      chk("empty_pushpop.nonce", tx_nonce, 32'hABCD);
      step(0, 0, 0, 1, 0);

      for (int i = 0; i < 10; i++) step(0, 1, 32'h100 + 32'(i), 0, 0);
      chk("full.count", 32'(tx_count), 32'd8);
      chk("full.ovf", 32'(tx_overflow_count), 32'd2);
      chk("full.head", tx_nonce, 32'h100);
      step(0, 1, 32'h200, 1, 0);
      chk("full_pushpop.count", 32'(tx_count), 32'd8);
      chk("full_pushpop.ovf", 32'(tx_overflow_count), 32'd2);
      chk("full_pushpop.head", tx_nonce, 32'h101);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      chk_model("drain");

      step(0, 1, 32'h1, 0, 0);
      step(0, 1, 32'h2, 0, 0);
      chk("pre_flush.count", 32'(tx_count), 32'd7);
      step(0, 1, 32'hDEAD, 1, 1);
      chk("flush.count", 32'(tx_count), 32'd0);
      chk("flush.valid", 32'(tx_valid), 32'd0);
      chk("flush.ovf_kept", 32'(tx_overflow_count), 32'd2);
      hold_cycles = (tx_holdoff === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 253; i++) begin
         step(0, 0, 0, 0, 0);
         if (tx_holdoff === 1'b1) hold_cycles++;
      end
      step(0, 1, 32'h5555, 0, 0);
      if (tx_holdoff === 1'b1) hold_cycles++;
      chk("holdoff.cycles", 32'(hold_cycles), 32'd254);
      chk("holdoff_end.push_dropped", 32'(tx_count), 32'd0);
      chk("holdoff_end.ovf", 32'(tx_overflow_count), 32'd2);
      step(0, 1, 32'h6666, 0, 0);
      chk("after_holdoff.count", 32'(tx_count), 32'd1);
      chk("after_holdoff.nonce", tx_nonce, 32'h6666);
      chk_model("after_holdoff");

      for (int i = 0; i < 20; i++) begin
         step(0, 1, 32'hC000 + 32'(i), 0, 0);
         exp_pops.push_back(32'hC000 + 32'(i));
         step(0, 0, 0, 1, 0);
         if (i == 0) chk("wrap.first_pop_head", tx_nonce, 32'hC000);
      end
      chk("wrap.count", 32'(tx_count), 32'd1);
      chk("wrap.head", tx_nonce, exp_pops[19]);
      chk_model("wrap");

      for (int i = 0; i < 400; i++) begin
         step(0, $urandom_range(1, 0) == 1, $urandom, $urandom_range(1, 0) == 1,
              $urandom_range(199, 0) == 0);
         chk_model("rand");
      end

      while (m_hold > 0) step(0, 0, 0, 0, 0);
      while (mq.size() < DEPTH) step(0, 1, $urandom, 0, 0);
      while (m_ovf < 32'hFFFE) step(0, 1, $urandom, 0, 0);
      chk("sat.fffe", 32'(tx_overflow_count), 32'h0000_FFFE);
      for (int i = 0; i < 3; i++) step(0, 1, $urandom, 0, 0);
      chk("sat.ffff", 32'(tx_overflow_count), 32'h0000_FFFF);
      chk_model("sat");

      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
      chk("mid_holdoff", 32'(tx_holdoff), 32'd1);
      step(1, 1, 32'h77, 1, 1);
      chk_reset_values("reset_mid_holdoff");
      step(0, 1, 32'h88, 0, 0);
      chk("post_reset.push", tx_nonce, 32'h88);
      chk_model("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
